// File: rtl/smg_scan_n.sv
// ============================================================================
// Module      : smg_scan_n
// Description : Parametrised multiplexed 7-segment scanner with tear-free load
//               handshake, anti-ghost blanking, polarity control, frame pulse.
//               Optional leading-zero blanking when SMG_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module smg_scan_n #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned DIG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     sm_wei,
    output logic [7:0]            sm_duan
);

    localparam int c_PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX  = c_PCNT_W'(SCAN_DIV - 1);
    localparam logic [c_DIG_W-1:0]  c_DIG_MAX   = c_DIG_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]   c_WEI_OFF   = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]          c_DUAN_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    logic [c_PCNT_W-1:0]  r_pcnt;
    logic [c_DIG_W-1:0]   r_dig;
    logic [4*DIGITS-1:0]  r_disp;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [DIGITS-1:0]    r_shadow_dp;
    logic                 r_pending;
    logic                 r_frame_done;
    logic [DIGITS-1:0]    r_wei;
    logic [7:0]           r_duan;

    logic                 w_slot_end;
    logic                 w_wrap;
    logic                 w_blank;
    logic [3:0]           w_nib [DIGITS];
    logic [3:0]           w_cur_nib;
    logic                 w_cur_dp;
    logic [6:0]           w_seg;
    logic [7:0]           w_raw;
    logic [DIGITS-1:0]    w_onehot;

    assign w_slot_end = (r_pcnt == c_PCNT_MAX);
    assign w_wrap     = w_slot_end && (r_dig == c_DIG_MAX);

    generate
        if (BLANK_CYC > 0) begin : g_blank
            localparam logic [c_PCNT_W-1:0] c_BLANK_CYC = c_PCNT_W'(BLANK_CYC);
            assign w_blank = (r_pcnt < c_BLANK_CYC);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_dig  <= '0;
        end else if (w_slot_end) begin
            r_pcnt <= '0;
            r_dig  <= w_wrap ? '0 : r_dig + c_DIG_W'(1);
        end else begin
            r_pcnt <= r_pcnt + c_PCNT_W'(1);
        end
    end

    // disp only moves at a frame boundary; a load coinciding with it bypasses shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= '0;
            r_disp_dp   <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pending   <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_disp    <= data_in;
                r_disp_dp <= dp_in;
            end else if (r_pending) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow    <= data_in;
            r_shadow_dp <= dp_in;
            r_pending   <= 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < int'(DIGITS); k++) begin : g_nib
            assign w_nib[k] = r_disp[4*k +: 4];
        end
    endgenerate

    assign w_cur_nib = w_nib[r_dig];
    assign w_cur_dp  = r_disp_dp[r_dig];

    always_comb begin
        w_seg = 7'h00;
        case (w_cur_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

`ifdef SMG_LZB_EN
    logic [DIGITS-1:0] w_lz;

    // digit k is a leading zero when it and every higher nibble are zero
    generate
        for (genvar k = 0; k < int'(DIGITS); k++) begin : g_lz
            if (k == 0) begin : g_lz0
                assign w_lz[k] = 1'b0;
            end else begin : g_lzk
                assign w_lz[k] = ~|r_disp[4*DIGITS-1:4*k];
            end
        end
    endgenerate

    assign w_raw = {w_cur_dp, (w_lz[r_dig] ? 7'h00 : w_seg)};
`else
    assign w_raw = {w_cur_dp, w_seg};
`endif

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_onehot[i] = (r_dig == c_DIG_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wei        <= c_WEI_OFF;
            r_duan       <= c_DUAN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_blank) begin
                r_wei  <= c_WEI_OFF;
                r_duan <= c_DUAN_OFF;
            end else begin
                r_wei  <= w_onehot ^ c_WEI_OFF;
                r_duan <= w_raw ^ c_DUAN_OFF;
            end
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign sm_wei     = r_wei;
    assign sm_duan    = r_duan;

endmodule

`default_nettype wire

// File: tb/tb_smg_scan_n.sv
// ============================================================================
// Module      : tb_smg_scan_n
// Description : Self-checking bench for smg_scan_n (DIGITS=4, SCAN_DIV=4,
//               BLANK_CYC=1, active-low digits and segments).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smg_scan_n;

    localparam int c_DIGITS = 4;
    localparam int c_DIV    = 4;
    localparam int c_BLANK  = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [3:0]  sm_wei;
    logic [7:0]  sm_duan;

    int n_checks = 0;
    int n_errors = 0;

    smg_scan_n #(
        .DIGITS(c_DIGITS), .SCAN_DIV(c_DIV), .BLANK_CYC(c_BLANK),
        .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
        .pending(pending), .frame_done(frame_done), .sm_wei(sm_wei), .sm_duan(sm_duan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          mcyc;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_disp_dp, m_shadow_dp;
    logic        m_pending;
    logic [3:0]  exp_wei = 4'hF;
    logic [7:0]  exp_duan = 8'hFF;
    logic        exp_pend = 1'b0;
    logic        exp_fd = 1'b0;
    logic        started = 1'b0;

    task automatic model_reset();
        mcyc = 0; m_disp = 0; m_shadow = 0; m_disp_dp = 0; m_shadow_dp = 0;
        m_pending = 0; exp_wei = 4'hF; exp_duan = 8'hFF; exp_pend = 0; exp_fd = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int pc, dg;
        logic wrap, lz;
        logic [3:0] nib;
        logic [7:0] raw;
        started = 1'b1;
        if (!rst_n) begin
            model_reset();
        end else begin
            pc   = mcyc % c_DIV;
            dg   = (mcyc / c_DIV) % c_DIGITS;
            wrap = ((mcyc % (c_DIV * c_DIGITS)) == c_DIV * c_DIGITS - 1);
            if (pc < c_BLANK) begin
                exp_wei  = 4'hF;
                exp_duan = 8'hFF;
            end else begin
                nib = 4'(m_disp >> (4 * dg));
                lz  = 1'b0;
`ifdef SMG_LZB_EN
                lz  = (dg > 0) && ((m_disp >> (4 * dg)) == 0);
`endif
                raw      = {m_disp_dp[dg], lz ? 7'h00 : seg7[nib]};
                exp_wei  = ~(4'b0001 << dg);
                exp_duan = ~raw;
            end
            exp_fd = wrap;
            if (wrap) begin
                if (load) begin
                    m_disp = data_in; m_disp_dp = dp_in;
                end else if (m_pending) begin
                    m_disp = m_shadow; m_disp_dp = m_shadow_dp;
                end
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow = data_in; m_shadow_dp = dp_in; m_pending = 1'b1;
            end
            exp_pend = m_pending;
            mcyc++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_sm_wei", 32'(sm_wei), 32'(exp_wei));
            chk("model_sm_duan", 32'(sm_duan), 32'(exp_duan));
            chk("model_pending", 32'(pending), 32'(exp_pend));
            chk("model_frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_wei(input logic [3:0] v, input string nm);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sm_wei == v) return;
        end
        chk({"timeout_", nm}, 32'(sm_wei), 32'(v));
    endtask

    task automatic wait_fd(input string nm);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        chk({"timeout_", nm}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int fd_cnt;
        rst_n = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sm_wei", 32'(sm_wei), 32'hF);
        chk("rst_sm_duan", 32'(sm_duan), 32'hFF);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        fd_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (i == 1) chk("first_blank_wei", 32'(sm_wei), 32'hF);
            if (i == 2) begin
                chk("first_dig0_wei", 32'(sm_wei), 32'hE);
                chk("first_dig0_duan", 32'(sm_duan), 32'hC0);
            end
            if (i == 16) chk("fd_at_16", 32'(frame_done), 32'd1);
        end
        chk("fd_count_40", 32'(fd_cnt), 32'd2);

        // mid-frame load of 1234
        data_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("pending_after_load", 32'(pending), 32'd1);
        wait_fd("fd_1234");
        chk("pending_after_wrap", 32'(pending), 32'd0);
        wait_wei(4'b1110, "d0_1234");
        chk("dig0_is_4", 32'(sm_duan), 32'h99);
        wait_wei(4'b0111, "d3_1234");
        chk("dig3_is_1", 32'(sm_duan), 32'hF9);

        // two loads in one frame: last one wins
        wait_fd("fd_pre_two");
        repeat (3) @(negedge clk);
        data_in = 16'hAAAA; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        data_in = 16'h00F0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_fd("fd_two");
        chk("pending_two_cleared", 32'(pending), 32'd0);
        wait_wei(4'b1101, "d1_00f0");
        chk("dig1_is_F", 32'(sm_duan), 32'h8E);
        wait_wei(4'b0111, "d3_00f0");
`ifdef SMG_LZB_EN
        chk("dig3_lzb_blank", 32'(sm_duan), 32'hFF);
`else
        chk("dig3_is_0", 32'(sm_duan), 32'hC0);
`endif

        // load coincident with wrap
        wait_fd("fd_pre_coinc");
        repeat (15) @(negedge clk);
        data_in = 16'h0050; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("coinc_fd", 32'(frame_done), 32'd1);
        chk("coinc_pending", 32'(pending), 32'd0);
        wait_wei(4'b1110, "d0_0050");
        chk("coinc_dig0_is_0", 32'(sm_duan), 32'hC0);
        wait_wei(4'b1101, "d1_0050");
        chk("coinc_dig1_is_5", 32'(sm_duan), 32'h92);
        wait_wei(4'b1011, "d2_0050");
`ifdef SMG_LZB_EN
        chk("coinc_dig2_lzb", 32'(sm_duan), 32'hFF);
`else
        chk("coinc_dig2_is_0", 32'(sm_duan), 32'hC0);
`endif

        // asynchronous reset during the digit 2 slot
        wait_fd("fd_pre_rst");
        wait_wei(4'b1011, "d2_pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wei", 32'(sm_wei), 32'hF);
        chk("async_rst_duan", 32'(sm_duan), 32'hFF);
        chk("async_rst_pending", 32'(pending), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerun_blank_wei", 32'(sm_wei), 32'hF);
        @(negedge clk);
        chk("rerun_dig0_wei", 32'(sm_wei), 32'hE);
        chk("rerun_dig0_duan", 32'(sm_duan), 32'hC0);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
